// File: rtl/converter_pkg.sv
// -----------------------------------------------------------------------------
// converter_pkg
//   Shared definitions for the delay converter control path.
//   - TAP_W / FINE_W / K_W : field widths of the k_sgn control word
//   - state_t              : conversion FSM states
//   - k_word_t             : packed view of k_sgn = {mux_sel, ctrl_gen}
//   - make_k()             : builds a k_word_t from a tap index and fine code
// -----------------------------------------------------------------------------
package converter_pkg;

    localparam int TAP_W  = 5;
    localparam int FINE_W = 7;
    localparam int K_W    = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Field order matches the wire order of k_sgn: tap select in the MSBs.
    typedef struct packed {
        logic [TAP_W-1:0]  mux_sel;
        logic [FINE_W-1:0] ctrl_gen;
    } k_word_t;

    function automatic k_word_t make_k(input logic [TAP_W-1:0]  tap,
                                       input logic [FINE_W-1:0] fine);
        k_word_t k;
        k.mux_sel  = tap;
        k.ctrl_gen = fine;
        return k;
    endfunction

endpackage

// File: rtl/delay_code_gen_if.sv
// -----------------------------------------------------------------------------
// delay_code_gen_if
//   Request handshake between a delay requester and delay_code_gen.
//   Ports (signals):
//     in_valid  : requester has a delay value
//     in_ready  : converter can accept a value this cycle
//     in_delay  : requested delay in fine-delay units (DLY_W bits)
//   Modports:
//     master : the requester (drives in_valid/in_delay)
//     slave  : the converter (drives in_ready)
// -----------------------------------------------------------------------------
interface delay_code_gen_if #(
    parameter int DLY_W = 12
);

    logic             in_valid;
    logic             in_ready;
    logic [DLY_W-1:0] in_delay;

    modport master (
        output in_valid,
        output in_delay,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_delay,
        output in_ready
    );

endinterface

// File: rtl/delay_code_gen.sv
// -----------------------------------------------------------------------------
// delay_code_gen
//   Splits a requested delay (fine units) into a coarse tap index and a fine
//   code by repeated subtraction of FINE_PER_TAP, one step per clock. The
//   result waits in a pending register and is only moved to k_sgn on an
//   apply strobe, so downstream tap mux / fine generator never see a code
//   change in the middle of an event.
//
//   Parameters:
//     DLY_W        : width of the requested delay
//     FINE_PER_TAP : fine steps per coarse tap (1..128)
//     MAX_TAP      : highest coarse tap index
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     req          : request handshake (in_valid / in_ready / in_delay)
//     apply        : strobe moving the pending code to k_sgn (honoured in HOLD)
//     pend_valid   : a converted code is waiting for apply
//     k_sgn        : applied control word {mux_sel[4:0], ctrl_gen[6:0]}
//     sat          : the applied code was clamped to the top tap
//     busy         : subtract loop running
// -----------------------------------------------------------------------------
module delay_code_gen
    import converter_pkg::*;
#(
    parameter int DLY_W        = 12,
    parameter int FINE_PER_TAP = 100,
    parameter int MAX_TAP      = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    delay_code_gen_if.slave       req,
    input  logic                  apply,
    output logic                  pend_valid,
    output logic [K_W-1:0]        k_sgn,
    output logic                  sat,
    output logic                  busy
);

    localparam logic [DLY_W-1:0]  FINE_STEP  = DLY_W'(FINE_PER_TAP);
    localparam logic [TAP_W-1:0]  TAP_LAST   = TAP_W'(MAX_TAP);
    localparam logic [FINE_W-1:0] FINE_CLAMP = FINE_W'(FINE_PER_TAP - 1);

    state_t           state_q, state_d;
    logic [DLY_W-1:0] rem_q,   rem_d;
    logic [TAP_W-1:0] tap_q,   tap_d;
    k_word_t          pend_q,  pend_d;
    logic             pend_sat_q, pend_sat_d;
    k_word_t          k_q,     k_d;
    logic             sat_q,   sat_d;

    // -------------------------------------------------------------------------
    // Next-state and datapath updates.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        rem_d      = rem_q;
        tap_d      = tap_q;
        pend_d     = pend_q;
        pend_sat_d = pend_sat_q;
        k_d        = k_q;
        sat_d      = sat_q;

        unique case (state_q)
            IDLE: begin
                if (req.in_valid) begin
                    rem_d   = req.in_delay;
                    tap_d   = '0;
                    state_d = DIV;
                end
            end

            DIV: begin
                if (rem_q >= FINE_STEP) begin
                    if (tap_q < TAP_LAST) begin
                        // Guarded by the compare above, so this never wraps.
                        rem_d = rem_q - FINE_STEP;
                        tap_d = tap_q + 1'b1;
                    end else begin
                        // Out of taps with a full tap still left over: clamp
                        // to the largest code the hardware can represent.
                        pend_d     = make_k(TAP_LAST, FINE_CLAMP);
                        pend_sat_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else begin
                    // rem < FINE_PER_TAP <= 128, so the low bits hold it all.
                    pend_d     = make_k(tap_q, rem_q[FINE_W-1:0]);
                    pend_sat_d = 1'b0;
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                if (apply) begin
                    k_d     = pend_q;
                    sat_d   = pend_sat_q;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers. Reset drops any conversion in flight and
    // returns every output to its idle value immediately.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            tap_q      <= '0;
            pend_q     <= '0;
            pend_sat_q <= 1'b0;
            k_q        <= '0;
            sat_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            rem_q      <= rem_d;
            tap_q      <= tap_d;
            pend_q     <= pend_d;
            pend_sat_q <= pend_sat_d;
            k_q        <= k_d;
            sat_q      <= sat_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: status is decoded straight from the state register, the
    // control word comes from its own register and only moves on apply.
    // -------------------------------------------------------------------------
    assign req.in_ready = (state_q == IDLE);
    assign busy         = (state_q == DIV);
    assign pend_valid   = (state_q == HOLD);
    assign k_sgn        = k_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_delay_code_gen.sv
// -----------------------------------------------------------------------------
// tb_delay_code_gen
//   Directed self-checking bench for delay_code_gen with FINE_PER_TAP=100,
//   MAX_TAP=31. Expected codes are hand-computed: k = tap*128 + fine.
// -----------------------------------------------------------------------------
module tb_delay_code_gen;
    import converter_pkg::*;

    localparam int DLY_W = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           apply = 1'b0;
    logic           pend_valid;
    logic [K_W-1:0] k_sgn;
    logic           sat;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    delay_code_gen_if #(.DLY_W(DLY_W)) req_if ();

    delay_code_gen #(
        .DLY_W        (DLY_W),
        .FINE_PER_TAP (100),
        .MAX_TAP      (31)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req_if),
        .apply      (apply),
        .pend_valid (pend_valid),
        .k_sgn      (k_sgn),
        .sat        (sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_k_sgn"},      32'(k_sgn),           32'h0);
        check({tag, "_sat"},        32'(sat),             32'h0);
        check({tag, "_pend_valid"}, 32'(pend_valid),      32'h0);
        check({tag, "_busy"},       32'(busy),            32'h0);
        check({tag, "_in_ready"},   32'(req_if.in_ready), 32'h1);
    endtask

    // Present a value and let it be accepted on the next edge.
    task automatic send(input string tag, input logic [DLY_W-1:0] d);
        req_if.in_valid = 1'b1;
        req_if.in_delay = d;
        check({tag, "_ready_pre"}, 32'(req_if.in_ready), 32'h1);
        tick();
        req_if.in_valid = 1'b0;
        check({tag, "_busy_post"},  32'(busy),            32'h1);
        check({tag, "_ready_post"}, 32'(req_if.in_ready), 32'h0);
    endtask

    // Count edges after acceptance until pend_valid rises (bounded).
    task automatic wait_pend(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!pend_valid && cycles < 64);
    endtask

    task automatic pulse_apply();
        apply = 1'b1;
        tick();
        apply = 1'b0;
    endtask

    task automatic convert(input string tag, input logic [DLY_W-1:0] d,
                           input logic [K_W-1:0] exp_k, input logic exp_sat,
                           input int exp_cycles);
        int c;
        send(tag, d);
        wait_pend(c);
        check({tag, "_cycles"}, 32'(c), 32'(exp_cycles));
        pulse_apply();
        check({tag, "_k_sgn"},    32'(k_sgn),           32'(exp_k));
        check({tag, "_sat"},      32'(sat),             32'(exp_sat));
        check({tag, "_pend_clr"}, 32'(pend_valid),      32'h0);
        check({tag, "_ready"},    32'(req_if.in_ready), 32'h1);
    endtask

    initial begin
        int c;
        req_if.in_valid = 1'b0;
        req_if.in_delay = '0;

        // Reset values, visible while reset is held.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic conversions, including the tap boundary and clamp cases.
        convert("d0",    12'd0,    12'h000, 1'b0, 1);
        convert("d1234", 12'd1234, 12'h622, 1'b0, 13);
        convert("d3199", 12'd3199, 12'hFE3, 1'b0, 32);
        convert("d3200", 12'd3200, 12'hFE3, 1'b1, 32);
        convert("d4095", 12'd4095, 12'hFE3, 1'b1, 32);
        convert("d150",  12'd150,  12'h0B2, 1'b0, 2);

        // in_valid held with a new value through DIV and HOLD.
        send("hold500", 12'd500);
        req_if.in_valid = 1'b1;
        req_if.in_delay = 12'd777;
        wait_pend(c);
        check("hold500_cycles", 32'(c), 32'd6);
        tick();
        tick();
        check("hold_ready_low", 32'(req_if.in_ready), 32'h0);
        check("hold_pend",      32'(pend_valid),      32'h1);
        check("hold_old_k",     32'(k_sgn),           32'h0B2);
        pulse_apply();
        check("hold500_k",      32'(k_sgn),           32'h280);
        check("hold_no_reacc",  32'(busy),            32'h0);
        check("hold_ready_up",  32'(req_if.in_ready), 32'h1);
        tick();
        req_if.in_valid = 1'b0;
        check("acc777_busy", 32'(busy), 32'h1);
        wait_pend(c);
        check("acc777_cycles", 32'(c),     32'd8);
        check("acc777_old_k",  32'(k_sgn), 32'h280);
        pulse_apply();
        check("acc777_k",   32'(k_sgn), 32'h3CD);
        check("acc777_sat", 32'(sat),   32'h0);

        // apply in IDLE is ignored.
        pulse_apply();
        check("idle_apply_k",     32'(k_sgn),           32'h3CD);
        check("idle_apply_ready", 32'(req_if.in_ready), 32'h1);
        check("idle_apply_busy",  32'(busy),            32'h0);

        // apply in DIV, including the finishing cycle, is ignored.
        send("d1000", 12'd1000);
        pulse_apply();
        check("div_apply_busy", 32'(busy),  32'h1);
        check("div_apply_k",    32'(k_sgn), 32'h3CD);
        repeat (9) tick();
        check("div_last_pend", 32'(pend_valid), 32'h0);
        check("div_last_busy", 32'(busy),       32'h1);
        pulse_apply();
        check("fin_apply_pend", 32'(pend_valid), 32'h1);
        check("fin_apply_k",    32'(k_sgn),      32'h3CD);
        pulse_apply();
        check("d1000_k", 32'(k_sgn), 32'h500);

        // Reset in the middle of a conversion.
        send("d2000a", 12'd2000);
        repeat (5) tick();
        rst_n = 1'b0;
        #1 check_reset_outputs("rst_div");
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_div_ready", 32'(req_if.in_ready), 32'h1);
        convert("d2000", 12'd2000, 12'hA00, 1'b0, 21);

        // Reset while a code is pending, after a saturated code was applied.
        convert("d4095b", 12'd4095, 12'hFE3, 1'b1, 32);
        send("d99", 12'd99);
        wait_pend(c);
        check("d99_cycles", 32'(c),          32'd1);
        check("d99_pend",   32'(pend_valid), 32'h1);
        rst_n = 1'b0;
        #1 check_reset_outputs("rst_hold");
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_hold_ready", 32'(req_if.in_ready), 32'h1);
        convert("d1234b", 12'd1234, 12'h622, 1'b0, 13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
